// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, issue-state encoding and FIFO entry type for the AES input packer
// Ports: none (package). Imported by aes_blk_fifo and aes_in_packer.
package aes_pkg;

    localparam int BLOCK_W       = 128;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_e;

    // One queued block together with the mode captured on its first word.
    typedef struct packed {
        logic               mode;
        logic [BLOCK_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/aes_in_packer_if.sv
// rtl/aes_in_packer_if.sv - word stream, AES core handshake and status signals of the packer
// Ports: none; master drives s_* and the core status inputs, slave (the packer) drives
// s_ready, the aes_data_in* issue outputs, blk_count and pad_seen.
interface aes_in_packer_if #(
    parameter int CNT_W = 16
);

    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_data;
    logic              s_last;
    logic              s_mode;
    logic              aes_rk_ready;
    logic              aes_busy;
    logic              aes_done;
    logic              aes_data_in_valid;
    logic [127:0]      aes_data_in;
    logic              aes_slt_module;
    logic [CNT_W-1:0]  blk_count;
    logic              pad_seen;

    modport master (
        output s_valid, s_data, s_last, s_mode, aes_rk_ready, aes_busy, aes_done,
        input  s_ready, aes_data_in_valid, aes_data_in, aes_slt_module, blk_count, pad_seen
    );

    modport slave (
        input  s_valid, s_data, s_last, s_mode, aes_rk_ready, aes_busy, aes_done,
        output s_ready, aes_data_in_valid, aes_data_in, aes_slt_module, blk_count, pad_seen
    );

endinterface

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - two-entry queue of assembled blocks awaiting issue to the core
// Ports: clk, rst (sync, active-high); push/wr_data enqueue; pop dequeues the head;
// count is the occupancy 0..2; rd_data is the current head entry.
module aes_blk_fifo
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t wr_data,
    input  logic        pop,
    output logic [1:0]  count,
    output fifo_entry_t rd_data
);

    fifo_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        push_ok;
    logic        pop_ok;

    // A push into a full queue is only accepted when the head leaves on the same edge.
    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/aes_in_packer.sv
// rtl/aes_in_packer.sv - packs 32-bit words into 128-bit blocks and issues them to the AES core
// Ports: clk, rst (sync, active-high); bus (slave) carries the word stream, the core
// handshake (rk_ready/busy/done in, data_in_valid/data_in/slt_module out) and status.
module aes_in_packer
    import aes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    aes_in_packer_if.slave  bus
);

    logic [1:0]         word_cnt_q, word_cnt_d;
    logic [95:0]        partial_q, partial_d;
    logic               mode_q, mode_d;
    logic               cur_mode;
    logic               accept;
    logic               complete;
    logic [BLOCK_W-1:0] blk;
    fifo_entry_t        fifo_wr;
    fifo_entry_t        fifo_rd;
    logic [1:0]         fifo_count;

    issue_state_e       state_q, state_d;
    logic               issue;
    logic [BLOCK_W-1:0] data_q;
    logic               slt_q;
    logic               valid_q;
    logic               pad_q;
    logic [CNT_W-1:0]   cnt_q;

    // Ready stays low while full even mid-block; this keeps the push path free of stall cases.
    assign bus.s_ready = !rst && (fifo_count < 2'd2);
    assign accept      = bus.s_valid && bus.s_ready;
    assign cur_mode    = (word_cnt_q == 2'd0) ? bus.s_mode : mode_q;
    assign complete    = accept && ((word_cnt_q == 2'd3) || bus.s_last);

    // blk is the block as it would look if the current word closed it. The partial register
    // is cleared on every completion, so words beyond the current one are already zero.
    always_comb begin
        blk        = {partial_q, 32'h0};
        partial_d  = partial_q;
        word_cnt_d = word_cnt_q;
        mode_d     = mode_q;
        case (word_cnt_q)
            2'd0:    blk[127:96] = bus.s_data;
            2'd1:    blk[95:64]  = bus.s_data;
            2'd2:    blk[63:32]  = bus.s_data;
            default: blk[31:0]   = bus.s_data;
        endcase
        if (accept) begin
            if (complete) begin
                partial_d  = '0;
                word_cnt_d = 2'd0;
            end else begin
                partial_d  = blk[127:32];
                word_cnt_d = word_cnt_q + 2'd1;
                mode_d     = cur_mode;
            end
        end
        fifo_wr.mode = cur_mode;
        fifo_wr.data = blk;
    end

    aes_blk_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (complete),
        .wr_data (fifo_wr),
        .pop     (issue),
        .count   (fifo_count),
        .rd_data (fifo_rd)
    );

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if ((fifo_count != 2'd0) && bus.aes_rk_ready && !bus.aes_busy) begin
                    state_d = ISSUE;
                    issue   = 1'b1;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.aes_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= 2'd0;
            partial_q  <= '0;
            mode_q     <= 1'b0;
            data_q     <= '0;
            slt_q      <= 1'b0;
            valid_q    <= 1'b0;
            pad_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            partial_q  <= partial_d;
            mode_q     <= mode_d;
            valid_q    <= issue;
            if (issue) begin
                data_q <= fifo_rd.data;
                slt_q  <= fifo_rd.mode;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (complete && (word_cnt_q != 2'd3)) begin
                pad_q <= 1'b1;
            end
        end
    end

    assign bus.aes_data_in_valid = valid_q;
    assign bus.aes_data_in       = data_q;
    assign bus.aes_slt_module    = slt_q;
    assign bus.blk_count         = cnt_q;
    assign bus.pad_seen          = pad_q;

endmodule

// File: tb/tb_aes_in_packer.sv
// tb/tb_aes_in_packer.sv - self-checking bench for aes_in_packer (CNT_W 16 and CNT_W 2 instances)
module tb_aes_in_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_valid, s_last, s_mode, rk, busy, done;
    logic [31:0] s_data;

    aes_in_packer_if #(.CNT_W(16)) if16 ();
    aes_in_packer_if #(.CNT_W(2))  if2 ();

    assign if16.s_valid = s_valid;  assign if2.s_valid = s_valid;
    assign if16.s_data  = s_data;   assign if2.s_data  = s_data;
    assign if16.s_last  = s_last;   assign if2.s_last  = s_last;
    assign if16.s_mode  = s_mode;   assign if2.s_mode  = s_mode;
    assign if16.aes_rk_ready = rk;  assign if2.aes_rk_ready = rk;
    assign if16.aes_busy = busy;    assign if2.aes_busy = busy;
    assign if16.aes_done = done;    assign if2.aes_done = done;

    aes_in_packer #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    aes_in_packer #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         mode;
        logic [127:0] data;
    } exp_t;

    exp_t         exp_q [$];
    int           exp_cnt   = 0;
    logic         exp_pad   = 1'b0;
    logic [127:0] last_data = '0;
    logic         last_mode = 1'b0;
    logic         prev_valid = 1'b0;
    logic         rst_seen  = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rst_seen = rst;

    // Model: blocks leave strictly in the order they were completed, each issue bumps the
    // count, outputs hold between issues, and a reset edge empties everything.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            exp_q.delete();
            exp_cnt   = 0;
            exp_pad   = 1'b0;
            last_data = '0;
            last_mode = 1'b0;
        end
        if (if16.aes_data_in_valid) begin
            if (prev_valid) fail_now("valid_single_cycle");
            if (exp_q.size() == 0) begin
                fail_now("unexpected_issue");
            end else begin
                e = exp_q.pop_front();
                chk("issue_data", if16.aes_data_in, e.data);
                chk("issue_mode", if16.aes_slt_module, e.mode);
                last_data = e.data;
                last_mode = e.mode;
                exp_cnt++;
            end
        end else begin
            chk("hold_data", if16.aes_data_in, last_data);
            chk("hold_mode", if16.aes_slt_module, last_mode);
        end
        chk("dut2_data", if2.aes_data_in, last_data);
        chk("blk_count16", if16.blk_count, exp_cnt % 65536);
        chk("blk_count2", if2.blk_count, exp_cnt % 4);
        chk("pad_seen", if16.pad_seen, exp_pad);
        chk("pad_seen2", if2.pad_seen, exp_pad);
        prev_valid = if16.aes_data_in_valid;
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic mode);
        logic rdy;
        bit   ok = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_mode  = mode;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = if16.s_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!ok) fail_now("word_accept");
    endtask

    // Later words carry the opposite mode so that first-word capture is exercised.
    task automatic send_msg(input logic [31:0] w0, w1, w2, w3, input int n, input logic mode);
        logic [31:0]  w [4];
        logic [127:0] b = '0;
        exp_t         e;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < n; k++) begin
            send_word(w[k], k == n - 1, (k == 0) ? mode : ~mode);
            b[127 - 32*k -: 32] = w[k];
        end
        e.mode = mode;
        e.data = b;
        exp_q.push_back(e);
        if (n < 4) exp_pad = 1'b1;
    endtask

    task automatic wait_valid(input int max, input string name);
        bit found = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (if16.aes_data_in_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) fail_now(name);
        step();
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // Called right after an edge that should make an issue possible on the next edge.
    task automatic check_next_issue(input string name);
        @(negedge clk);
        chk({name, "_early"}, if16.aes_data_in_valid, 1'b0);
        @(negedge clk);
        chk({name, "_pulse"}, if16.aes_data_in_valid, 1'b1);
        step();
    endtask

    task automatic count_issues(input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if16.aes_data_in_valid) nv++;
        end
        step();
    endtask

    int wrap_seq [5] = '{1, 2, 3, 0, 1};

    initial begin
        int nv;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_mode = 1'b0;
        rk = 1'b0; busy = 1'b0; done = 1'b0;

        @(negedge clk);
        chk("rst_s_ready", if16.s_ready, 1'b0);
        chk("rst_valid", if16.aes_data_in_valid, 1'b0);
        chk("rst_count", if16.blk_count, 16'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", if16.s_ready, 1'b1);
        step();

        // Basic issue
        rk = 1'b1;
        send_msg(32'hd7e5dbd3, 32'h324595f8, 32'hfdc7d7c5, 32'h71da6c2a, 4, 1'b0);
        check_next_issue("basic");
        chk("basic_data", if16.aes_data_in, 128'hd7e5dbd3324595f8fdc7d7c571da6c2a);
        chk("basic_mode", if16.aes_slt_module, 1'b0);
        chk("basic_count", if16.blk_count, 16'd1);
        chk("basic_pad", if16.pad_seen, 1'b0);
        pulse_done();

        // Early s_last
        send_msg(32'h01234567, 32'h89abcdef, 32'h0, 32'h0, 2, 1'b1);
        check_next_issue("early");
        chk("early_data", if16.aes_data_in, 128'h0123456789abcdef0000000000000000);
        chk("early_mode", if16.aes_slt_module, 1'b1);
        chk("early_pad", if16.pad_seen, 1'b1);
        pulse_done();

        // Keys not ready: two blocks fill the queue, third waits
        rk = 1'b0;
        send_msg(32'ha0000000, 32'ha0000001, 32'ha0000002, 32'ha0000003, 4, 1'b0);
        send_msg(32'hb0000000, 32'hb0000001, 32'hb0000002, 32'hb0000003, 4, 1'b1);
        @(negedge clk);
        chk("full_s_ready", if16.s_ready, 1'b0);
        step();
        count_issues(5, nv);
        chk("keys_no_issue", nv, 0);
        rk = 1'b1;
        fork
            send_msg(32'hc0000000, 32'hc0000001, 32'hc0000002, 32'hc0000003, 4, 1'b0);
            wait_valid(10, "issue_a");
        join
        pulse_done();
        check_next_issue("next_b");
        chk("next_b_data", if16.aes_data_in, 128'hb0000000b0000001b0000002b0000003);
        pulse_done();
        check_next_issue("next_c");
        chk("next_c_data", if16.aes_data_in, 128'hc0000000c0000001c0000002c0000003);
        pulse_done();

        // Busy in IDLE blocks issue; done in IDLE is ignored; busy in WAIT is ignored
        busy = 1'b1;
        send_msg(32'hd0000000, 32'hd0000001, 32'hd0000002, 32'hd0000003, 4, 1'b1);
        count_issues(4, nv);
        chk("busy_no_issue", nv, 0);
        pulse_done();
        count_issues(2, nv);
        chk("done_idle_no_issue", nv, 0);
        busy = 1'b0;
        wait_valid(4, "issue_after_busy");
        busy = 1'b1;
        pulse_done();
        busy = 1'b0;
        send_msg(32'he0000000, 32'he0000001, 32'he0000002, 32'he0000003, 4, 1'b0);
        check_next_issue("after_wait");
        pulse_done();

        // Reset with one queued block and two words of a partial block
        rk = 1'b0;
        send_msg(32'hf0000000, 32'hf0000001, 32'hf0000002, 32'hf0000003, 4, 1'b1);
        send_word(32'hdeadbeef, 1'b0, 1'b1);
        send_word(32'hcafef00d, 1'b0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", if16.s_ready, 1'b0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data", if16.aes_data_in, 128'h0);
        chk("midrst_count", if16.blk_count, 16'd0);
        chk("midrst_pad", if16.pad_seen, 1'b0);
        chk("midrst_s_ready_after", if16.s_ready, 1'b1);
        step();
        rk = 1'b1;
        send_msg(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 1'b1);
        check_next_issue("fresh");
        chk("fresh_data", if16.aes_data_in, 128'h11111111222222223333333344444444);
        chk("fresh_mode", if16.aes_slt_module, 1'b1);
        chk("fresh_count", if16.blk_count, 16'd1);
        pulse_done();

        // Counter wrap on the 2-bit instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_msg(32'h5a000000 + i, 32'h5a100000 + i, 32'h5a200000 + i, 32'h5a300000 + i, 4, i[0]);
            wait_valid(6, "wrap_issue");
            chk("wrap_count2", if2.blk_count, wrap_seq[i]);
            chk("wrap_count16", if16.blk_count, i + 1);
            pulse_done();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
